// File: rtl/npc_fetch.sv
// Fetch-stage PC register and next-PC sequencer.
// It holds a one-entry pending-redirect buffer so that a D-stage redirect raised during a stall is not lost.
module npc_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_4180,
    parameter logic [31:0] IM_BASE    = 32'h0000_3000,
    parameter logic [31:0] IM_LIMIT   = 32'h0000_6FFC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        jump_en,
    input  logic [31:0] jump_target,
    input  logic        branch_en,
    input  logic [31:0] branch_target,
    input  logic        jr_en,
    input  logic [31:0] jr_target,
    input  logic        exc_en,
    input  logic        eret_en,
    input  logic [31:0] epc,
    output logic [31:0] pc_f,
    output logic [31:0] pc4_f,
    output logic        adel_f,
    output logic        pend_valid
);

    logic [31:0] pend_target;
    logic        d_req;
    logic [31:0] d_tgt;

    // The decoder should raise only one D enable at a time.
    // If it raises several, jr wins over jump, and jump wins over branch, with no error signalled.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        d_req = jr_en | jump_en | branch_en;
        d_tgt = branch_target;
        if (jr_en)
            d_tgt = jr_target;
        else if (jump_en)
            d_tgt = jump_target;
    end

    // NOTE: state registers use non-blocking assignments so all updates see pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_f        <= RESET_PC;
            pend_valid  <= 1'b0;
            pend_target <= '0;
        end else if (exc_en) begin
            pc_f       <= EXC_VECTOR;
            pend_valid <= 1'b0;
        end else if (eret_en) begin
            pc_f       <= epc;
            pend_valid <= 1'b0;
        end else if (stall) begin
            if (d_req) begin
                pend_target <= d_tgt;
                pend_valid  <= 1'b1;
            end
        end else if (d_req) begin
            pc_f       <= d_tgt;
            pend_valid <= 1'b0;
        end else if (pend_valid) begin
            pc_f       <= pend_target;
            pend_valid <= 1'b0;
        end else begin
            pc_f <= pc_f + 32'd4;
        end
    end

    assign pc4_f  = pc_f + 32'd4;
    assign adel_f = (pc_f[1:0] != 2'b00) || (pc_f < IM_BASE) || (pc_f > IM_LIMIT);

endmodule
